seq_timing_ctrl: RTL

SEQ_TIMING_CTRL -- requirements
Module: seq_timing_ctrl

---
 rtl/mano_pkg.sv | 10 +
 rtl/decoder_3to8.sv | 8 +
 rtl/seq_timing_ctrl.sv | 42 ++++
 3 files changed

// File: rtl/mano_pkg.sv
// mano_pkg: shared widths and instruction field positions for the timing/control slice
package mano_pkg;
  localparam int WORD_W  = 16;
  localparam int SC_W    = 3;
  localparam int T_N     = 8;
  localparam int OPC_HI  = 14;
  localparam int OPC_LO  = 12;
  localparam int IND_BIT = 15;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/decoder_3to8.sv
// decoder_3to8: enabled 3-bit to 8-bit one-hot decoder
module decoder_3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_dec
);
  always_comb o_dec = i_en ? 8'(8'd1 << i_sel) : 8'h00;
endmodule

// File: rtl/seq_timing_ctrl.sv
// seq_timing_ctrl: run flag, sequence counter and instruction register with T/D decode
module seq_timing_ctrl
  import mano_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              HLT,
  input  logic              SC_CLR,
  input  logic              IR_LD,
  input  logic [WORD_W-1:0] MEM_DATA,
  output logic [T_N-1:0]    T,
  output logic [T_N-1:0]    D,
  output logic              I,
  output logic [WORD_W-1:0] IR,
  output logic [SC_W-1:0]   SC,
  output logic              S
);
  logic              r_s;
  logic [SC_W-1:0]   r_sc;
  word_t             r_ir;
  logic [2:0]        w_opc;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_s  <= 1'b0;
      r_sc <= '0;
      r_ir <= '0;
    end else begin
      r_s  <= HLT ? 1'b0 : START ? 1'b1 : r_s;
      r_sc <= SC_CLR ? '0 : r_s ? r_sc + 1'b1 : r_sc;
      if (IR_LD && r_s) r_ir <= MEM_DATA;
    end
  always_comb begin
    w_opc = r_ir[OPC_HI:OPC_LO];
    S     = r_s;
    SC    = r_sc;
    IR    = r_ir;
    I     = r_ir[IND_BIT];
  end
  decoder_3to8 u_t_dec (.i_sel(r_sc),  .i_en(r_s),  .o_dec(T));
  decoder_3to8 u_d_dec (.i_sel(w_opc), .i_en(1'b1), .o_dec(D));
endmodule
